// File: rtl/verlet_step_scheduler_pkg.sv
// Shared definitions for the Verlet frame sequencer: fixed-point format,
// FSM state encoding and an index-width helper.
package verlet_step_scheduler_pkg;

  localparam int FRAC_BITS = 12;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_VERLET     = 3'd1,
    ST_SOLVE_REQ  = 3'd2,
    ST_SOLVE_WAIT = 3'd3,
    ST_WRITE      = 3'd4,
    ST_DONE       = 3'd5
  } state_t;

  // Width needed to index n items, never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/verlet_step_scheduler_sched_watchdog.sv
// Solver watchdog: down-counter loaded on clear, decremented while enabled;
// expired flags the final permitted wait cycle.
module sched_watchdog
  import verlet_step_scheduler_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = idx_width(TIMEOUT);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= LOAD;
    end else if (enable && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  // Terminal count is left unqualified so the FSM can gate it with solver_done.
  assign expired = (count == '0);

endmodule

// File: rtl/verlet_step_scheduler.sv
// Frame sequencer: one integration strobe, then NUM_ITERS relaxation passes
// over segments 1..NUM_NODES-1 through a shared constraint solver.
//
// state      | meaning
// IDLE       | waiting for start
// VERLET     | broadcast integration strobe
// SOLVE_REQ  | request solver for segment node_sel, arm watchdog
// SOLVE_WAIT | wait for solver_done or watchdog expiry
// WRITE      | constraint write-back strobe for node_sel
// DONE       | frame-complete pulse
module verlet_step_scheduler
  import verlet_step_scheduler_pkg::*;
#(
  parameter int                   NUM_NODES = 8,
  parameter int                   NUM_ITERS = 4,
  parameter logic [NUM_NODES-1:0] PIN_MASK  = {{(NUM_NODES-1){1'b0}}, 1'b1},
  parameter int                   TIMEOUT   = 64,
  localparam int                  IDX_W     = idx_width(NUM_NODES),
  localparam int                  ITER_W    = $clog2(NUM_ITERS) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 solver_done,
  output logic                 verlet_state,
  output logic [NUM_NODES-1:0] fix_constraint_state,
  output logic [IDX_W-1:0]     node_sel,
  output logic                 solver_start,
  output logic                 busy,
  output logic                 done,
  output logic [ITER_W-1:0]    iter,
  output logic [15:0]          step_count,
  output logic                 timeout_err
);

  localparam logic [IDX_W-1:0]  LAST_SEL  = IDX_W'(NUM_NODES - 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(NUM_ITERS - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic [15:0]        step_q, step_d;
  logic               err_q, err_d;
  logic               seg_to_q, seg_to_d;
  logic               wd_clear, wd_enable, wd_expired;

  sched_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      iter_q   <= '0;
      step_q   <= '0;
      err_q    <= 1'b0;
      seg_to_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      iter_q   <= iter_d;
      step_q   <= step_d;
      err_q    <= err_d;
      seg_to_q <= seg_to_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    sel_d                = sel_q;
    iter_d               = iter_q;
    step_d               = step_q;
    err_d                = err_q;
    seg_to_d             = seg_to_q;
    wd_clear             = 1'b0;
    wd_enable            = 1'b0;
    verlet_state         = 1'b0;
    solver_start         = 1'b0;
    done                 = 1'b0;
    fix_constraint_state = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_VERLET;
          err_d   = 1'b0;
          iter_d  = '0;
          sel_d   = IDX_W'(1);
        end
      end
      ST_VERLET: begin
        verlet_state = 1'b1;
        state_d      = ST_SOLVE_REQ;
      end
      ST_SOLVE_REQ: begin
        solver_start = 1'b1;
        wd_clear     = 1'b1;
        seg_to_d     = 1'b0;
        state_d      = ST_SOLVE_WAIT;
      end
      ST_SOLVE_WAIT: begin
        if (solver_done) begin
          state_d = ST_WRITE;
        end else begin
          wd_enable = 1'b1;
          if (wd_expired) begin
            seg_to_d = 1'b1;
            err_d    = 1'b1;
            state_d  = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        // Pinned nodes still go through the solver so frame timing is fixed.
        if (!seg_to_q && !PIN_MASK[sel_q]) begin
          fix_constraint_state = NUM_NODES'(1) << sel_q;
        end
        if (sel_q < LAST_SEL) begin
          sel_d   = sel_q + IDX_W'(1);
          state_d = ST_SOLVE_REQ;
        end else if (iter_q < LAST_ITER) begin
          iter_d  = iter_q + ITER_W'(1);
          sel_d   = IDX_W'(1);
          state_d = ST_SOLVE_REQ;
        end else begin
          step_d  = step_q + 16'd1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A reset cycle must never leak a strobe, whatever state is being left.
    if (reset) begin
      verlet_state         = 1'b0;
      solver_start         = 1'b0;
      done                 = 1'b0;
      fix_constraint_state = '0;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign node_sel    = sel_q;
  assign iter        = iter_q;
  assign step_count  = step_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_verlet_step_scheduler.sv
// Bench for verlet_step_scheduler: randomized solver latencies per segment,
// expected write-back order, frame length and error flag computed per frame.
module tb_verlet_step_scheduler;

  localparam int         N     = 8;
  localparam int         ITERS = 4;
  localparam int         TMO   = 64;
  localparam logic [7:0] PIN   = 8'b1000_0001;
  localparam int         SEGS  = ITERS * (N - 1);

  logic       clk = 1'b0;
  logic       reset, start, solver_done;
  logic       verlet_state, solver_start, busy, done, timeout_err;
  logic [7:0] fix_constraint_state;
  logic [2:0] node_sel, iter;
  logic [15:0] step_count;

  always #5 clk = ~clk;

  verlet_step_scheduler #(
    .NUM_NODES (N),
    .NUM_ITERS (ITERS),
    .PIN_MASK  (PIN),
    .TIMEOUT   (TMO)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .solver_done          (solver_done),
    .verlet_state         (verlet_state),
    .fix_constraint_state (fix_constraint_state),
    .node_sel             (node_sel),
    .solver_start         (solver_start),
    .busy                 (busy),
    .done                 (done),
    .iter                 (iter),
    .step_count           (step_count),
    .timeout_err          (timeout_err)
  );

  int checks = 0;
  int errors = 0;
  int lat_q[$];     // solver latency per segment in cycles after solver_start; 0 = never
  int exp_wr[$];
  int exp_len;
  bit exp_to;
  int exp_steps;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic build_model();
    exp_wr.delete();
    exp_len = 2;
    exp_to  = 1'b0;
    foreach (lat_q[i]) begin
      int k  = i % (N - 1) + 1;
      bit to = (lat_q[i] == 0) || (lat_q[i] > TMO);
      exp_len += 2 + (to ? TMO : lat_q[i]);
      if (to) exp_to = 1'b1;
      else if (!PIN[k]) exp_wr.push_back(k);
    end
  endtask

  task automatic fill_lat(input int lo, input int hi);
    lat_q.delete();
    repeat (SEGS) lat_q.push_back($urandom_range(hi, lo));
  endtask

  task automatic run_frame(input bit hold, input int rst_seg);
    int cyc = 0, seg = 0, due = -1, cur_sel = -1, n_verlet = 0, start_cyc = 0;
    bit got_done = 1'b0;
    build_model();
    if (busy) begin
      @(negedge clk);
      check("idle_gap", 32'(busy), 0);
    end
    start = 1'b1;
    while (!got_done && cyc <= exp_len + 8) begin
      @(negedge clk);
      cyc++;
      if (verlet_state) begin
        n_verlet++;
        check("verlet_cycle", cyc, 1);
        check("verlet_fix_excl", 32'(fix_constraint_state), 0);
      end
      if (cyc == 1) check("err_cleared", 32'(timeout_err), 0);
      if (solver_start) begin
        cur_sel = seg % (N - 1) + 1;
        check("seg_sel", 32'(node_sel), cur_sel);
        check("seg_iter", 32'(iter), seg / (N - 1));
        due = (seg < lat_q.size() && lat_q[seg] != 0) ? cyc + lat_q[seg] : -1;
        start_cyc = cyc;
        seg++;
      end else if (cur_sel >= 0 && !done) begin
        check("sel_stable", 32'(node_sel), cur_sel);
      end
      if (fix_constraint_state != 8'h00) begin
        check("fix_onehot", 32'($onehot(fix_constraint_state)), 1);
        if (exp_wr.size() == 0) check("fix_extra", 32'(fix_constraint_state), 0);
        else check("fix_node", 32'(fix_constraint_state), 1 << exp_wr.pop_front());
      end
      if (done) begin
        got_done = 1'b1;
        exp_steps++;
        check("done_cycle", cyc, exp_len);
        check("step_count", 32'(step_count), exp_steps & 16'hffff);
        check("timeout_err", 32'(timeout_err), 32'(exp_to));
        check("writes_left", exp_wr.size(), 0);
        check("verlet_count", n_verlet, 1);
        check("seg_count", seg, SEGS);
      end
      if (rst_seg >= 0 && seg == rst_seg + 1 && cyc == start_cyc + 3) begin
        reset = 1'b1;
        start = 1'b0;
        solver_done = 1'b0;
        #1;
        check("rst_cycle_quiet", 32'({verlet_state, solver_start, done, |fix_constraint_state}), 0);
        @(negedge clk);
        check("rst_outputs", 32'({verlet_state, solver_start, done, busy, timeout_err,
                                  fix_constraint_state, node_sel, iter}), 0);
        check("rst_step_count", 32'(step_count), 0);
        reset = 1'b0;
        exp_steps = 0;
        @(negedge clk);
        check("rst_after_quiet", 32'({verlet_state, done, busy, |fix_constraint_state}), 0);
        return;
      end
      solver_done = (cyc == due);
      if (got_done) start = hold;
      else start = hold ? 1'b1 : ($urandom_range(3, 0) == 0);
    end
    check("done_seen", 32'(got_done), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    solver_done = 1'b0;
    exp_steps = 0;
    repeat (3) @(negedge clk);
    check("reset_strobes", 32'({verlet_state, solver_start, done, busy, timeout_err}), 0);
    check("reset_fix", 32'(fix_constraint_state), 0);
    check("reset_sel_iter", 32'({node_sel, iter}), 0);
    check("reset_step_count", 32'(step_count), 0);
    reset = 1'b0;
    @(negedge clk);

    fill_lat(1, 1);
    run_frame(1'b0, -1);

    fill_lat(6, 6);
    run_frame(1'b0, -1);

    fill_lat(1, 12);
    lat_q[5]  = TMO;
    lat_q[20] = TMO + 1;
    run_frame(1'b0, -1);

    fill_lat(0, 0);
    run_frame(1'b0, -1);

    for (int f = 0; f < 3; f++) begin
      fill_lat(1, 4);
      run_frame(1'b1, -1);
    end
    start = 1'b0;

    fill_lat(10, 10);
    run_frame(1'b0, 2 * (N - 1) + 3);

    fill_lat(1, 1);
    run_frame(1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
